memoria_seq_aste: RTL and testbench

//   Parametrised single-port pattern RAM for asteroid/sequence data with a built-in playback engine.

---
 rtl/memoria_seq_aste_pkg.sv | 19 +
 rtl/memoria_seq_aste_lfsr16.sv | 30 +++
 rtl/memoria_seq_aste.sv | 166 ++++++++++++++++
 tb/tb_memoria_seq_aste.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/memoria_seq_aste_pkg.sv
// Shared definitions for the pattern RAM playback engine: state encoding and LFSR constants.
// Optional LFSR fill (MEM_LFSR_FILL_EN) reuses lfsr_step from here.
package memoria_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_OUT   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FILL  = 3'd4;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Galois form of x^16+x^14+x^13+x^11+1: shift right, fold taps in when bit 0 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/memoria_seq_aste_lfsr16.sv
// 16-bit Galois LFSR with seed load and step enable; only built with MEM_LFSR_FILL_EN.
// A zero seed is replaced by LFSR_DEFAULT_SEED so the register never locks up.
`ifdef MEM_LFSR_FILL_EN
module lfsr16
  import memoria_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      r_lfsr <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end else if (step) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign value = r_lfsr;

endmodule
`endif

// File: rtl/memoria_seq_aste.sv
// Single-port pattern RAM with registered-address read and a valid/ready playback engine.
// Define MEM_LFSR_FILL_EN to add the fill_start/fill_seed ports and the LFSR fill state.
module memoria_seq_aste
  import memoria_pkg::*;
#(
  parameter int    DATA_W    = 2,
  parameter int    DEPTH     = 16,
  parameter int    ADDR_W    = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  input  logic              play_start,
  input  logic [ADDR_W:0]   play_len,
  output logic              play_valid,
  input  logic              play_ready,
  output logic [DATA_W-1:0] play_data,
  output logic [ADDR_W-1:0] play_addr,
  output logic              busy,
  output logic              done
`ifdef MEM_LFSR_FILL_EN
  ,
  input  logic              fill_start,
  input  logic [15:0]       fill_seed
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_addr_reg;
  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [ADDR_W:0]   r_ptr;
  logic [ADDR_W:0]   r_len_c;
  logic [DATA_W-1:0] r_play_data;
  logic [ADDR_W-1:0] r_play_addr;

  logic [ADDR_W:0]   w_len_clamped;
  logic              w_last;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;

  // Power-on image only; reset never touches the array.
  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  assign w_len_clamped = (play_len > DEPTH_C) ? DEPTH_C : play_len;
  assign w_last        = (r_ptr == (r_len_c - PTR_ONE));

`ifdef MEM_LFSR_FILL_EN
  logic [15:0] w_lfsr;
  logic        w_fill_go;
  logic        w_fill_last;

  assign w_fill_go   = (r_state == ST_IDLE) && fill_start && !play_start;
  assign w_fill_last = (r_ptr == (DEPTH_C - PTR_ONE));

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_fill_go),
    .seed    (fill_seed),
    .step    (r_state == ST_FILL),
    .value   (w_lfsr)
  );
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (play_start) begin
          w_state_next = (play_len == '0) ? ST_DONE : ST_FETCH;
        end
`ifdef MEM_LFSR_FILL_EN
        else if (fill_start) begin
          w_state_next = ST_FILL;
        end
`endif
      end
      ST_FETCH: w_state_next = ST_OUT;
      ST_OUT: begin
        if (play_ready) w_state_next = w_last ? ST_DONE : ST_FETCH;
      end
      ST_DONE: w_state_next = ST_IDLE;
`ifdef MEM_LFSR_FILL_EN
      ST_FILL: begin
        if (w_fill_last) w_state_next = ST_DONE;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The engine owns the write port whenever it is not idle.
  always_comb begin
    w_mem_we    = we && (r_state == ST_IDLE);
    w_mem_waddr = addr;
    w_mem_wdata = data;
`ifdef MEM_LFSR_FILL_EN
    if (r_state == ST_FILL) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_ptr[ADDR_W-1:0];
      w_mem_wdata = w_lfsr[DATA_W-1:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_addr_reg  <= '0;
      r_ptr       <= '0;
      r_len_c     <= '0;
      r_play_data <= '0;
      r_play_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_addr_reg <= addr;
      case (r_state)
        ST_IDLE: begin
          if (play_start) begin
            r_ptr   <= '0;
            r_len_c <= w_len_clamped;
          end
`ifdef MEM_LFSR_FILL_EN
          else if (fill_start) begin
            r_ptr <= '0;
          end
`endif
        end
        ST_FETCH: begin
          r_play_data <= r_mem[r_ptr[ADDR_W-1:0]];
          r_play_addr <= r_ptr[ADDR_W-1:0];
        end
        ST_OUT: begin
          if (play_ready) r_ptr <= r_ptr + PTR_ONE;
        end
`ifdef MEM_LFSR_FILL_EN
        ST_FILL: r_ptr <= r_ptr + PTR_ONE;
`endif
        default: ;
      endcase
    end
  end

  assign q          = r_mem[r_addr_reg];
  assign play_valid = (r_state == ST_OUT);
  assign play_data  = r_play_data;
  assign play_addr  = r_play_addr;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_memoria_seq_aste.sv
// Directed-plus-random bench for memoria_seq_aste against an array model of RAM contents.
// Exercises MEM_LFSR_FILL_EN fill when that macro is defined.
module tb_memoria_seq_aste;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       we;
  logic [3:0] addr;
  logic [1:0] data;
  logic [1:0] q;
  logic       play_start;
  logic [4:0] play_len;
  logic       play_valid;
  logic       play_ready;
  logic [1:0] play_data;
  logic [3:0] play_addr;
  logic       busy;
  logic       done;
`ifdef MEM_LFSR_FILL_EN
  logic        fill_start;
  logic [15:0] fill_seed;
`endif

  int errors = 0;
  int checks = 0;
  logic [1:0] model [16];

  always #5 clk = ~clk;

  memoria_seq_aste dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .we         (we),
    .addr       (addr),
    .data       (data),
    .q          (q),
    .play_start (play_start),
    .play_len   (play_len),
    .play_valid (play_valid),
    .play_ready (play_ready),
    .play_data  (play_data),
    .play_addr  (play_addr),
    .busy       (busy),
    .done       (done)
`ifdef MEM_LFSR_FILL_EN
    ,
    .fill_start (fill_start),
    .fill_seed  (fill_seed)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input int a);
    addr = a[3:0];
    tick();
    chk(tag, {30'd0, q}, {30'd0, model[a]});
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for the first 5 valid cycles.
  task automatic run_play(input string tag, input int len, input int mode, input bit disturb);
    int  n_eff   = (len > 16) ? 16 : len;
    int  idx     = 0;
    int  cyc     = 0;
    int  lowcnt  = 0;
    bit  pending = 0;
    bit  got     = 0;
    play_start = 1'b1;
    play_len   = len[4:0];
    play_ready = (mode == 0);
    tick();
    play_start = 1'b0;
    we         = 1'b0;
    while (!got && cyc < 300) begin
      if (done) begin
        got = 1;
        chk({tag, " xfers"}, idx, n_eff);
        if (mode == 0) chk({tag, " cycles"}, cyc, 2 * n_eff);
      end else begin
        if (pending) chk({tag, " valid_held"}, {31'd0, play_valid}, 32'd1);
        if (play_valid && idx < 16) begin
          chk({tag, " data"}, {30'd0, play_data}, {30'd0, model[idx]});
          chk({tag, " addr"}, {28'd0, play_addr}, idx);
          case (mode)
            0:       play_ready = 1'b1;
            1:       play_ready = 1'($urandom % 2);
            default: begin play_ready = (lowcnt >= 5); lowcnt++; end
          endcase
          if (play_ready) begin
            $display("xfer %s addr=%0d data=%b", tag, play_addr, play_data);
            idx++;
            pending = 0;
          end else begin
            pending = 1;
          end
        end else begin
          play_ready = (mode == 1) ? 1'($urandom % 2) : (mode == 0);
          pending    = 0;
        end
        if (disturb) begin
          play_start = 1'($urandom % 2);
          play_len   = 5'd1;
          we         = 1'($urandom % 2);
          addr       = 4'd3;
          data       = ~model[3];
        end
        tick();
        cyc++;
      end
    end
    if (!got) chk({tag, " timeout"}, 32'd0, 32'd1);
    play_start = 1'b0;
    we         = 1'b0;
    play_ready = 1'b0;
    tick();
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

`ifdef MEM_LFSR_FILL_EN
  task automatic run_fill(input string tag, input logic [15:0] seed);
    logic [15:0] v;
    int cyc = 0;
    bit got = 0;
    v = (seed == 16'h0) ? 16'hACE1 : seed;
    for (int i = 0; i < 16; i++) begin
      model[i] = v[1:0];
      v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    end
    fill_seed  = seed;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    while (!got && cyc < 100) begin
      if (done) begin
        got = 1;
        chk({tag, " cycles"}, cyc, 16);
      end else begin
        if (busy !== 1'b1) chk({tag, " busy"}, {31'd0, busy}, 32'd1);
        tick();
        cyc++;
      end
    end
    if (!got) chk({tag, " timeout"}, 32'd0, 32'd1);
    tick();
    for (int i = 0; i < 16; i++) read_chk({tag, " mem"}, i);
  endtask
`endif

  initial begin
    reset_n    = 1'b0;
    we         = 1'b0;
    addr       = '0;
    data       = '0;
    play_start = 1'b0;
    play_len   = '0;
    play_ready = 1'b0;
`ifdef MEM_LFSR_FILL_EN
    fill_start = 1'b0;
    fill_seed  = '0;
`endif
    #12;
    chk("rst valid", {31'd0, play_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst pdata", {30'd0, play_data}, 32'd0);
    chk("rst paddr", {28'd0, play_addr}, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      case (i)
        0, 1:    model[i] = 2'b10;
        2, 3:    model[i] = 2'b00;
        default: model[i] = 2'($urandom % 4);
      endcase
      we = 1'b1; addr = i[3:0]; data = model[i];
      tick();
    end
    we = 1'b0;

    read_chk("read a2", 2);
    we = 1'b1; addr = 4'd5; data = 2'b11; model[5] = 2'b11;
    tick();
    we = 1'b0;
    read_chk("read a5", 5);
    for (int i = 0; i < 8; i++) read_chk("read rnd", int'($urandom % 16));

    run_play("len4", 4, 0, 0);
    run_play("len20", 20, 0, 0);
    run_play("len0", 0, 0, 0);
    run_play("bp", 7, 2, 0);
    run_play("busy", 16, 1, 1);
    read_chk("ram3 kept", 3);

    we = 1'b1; addr = 4'd0; data = 2'b01; model[0] = 2'b01;
    run_play("wr_start", 2, 0, 0);
    for (int k = 0; k < 4; k++) run_play("rnd", int'($urandom_range(1, 20)), 1, 0);

    play_start = 1'b1; play_len = 5'd16; play_ready = 1'b1;
    tick();
    play_start = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("arst valid", {31'd0, play_valid}, 32'd0);
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    reset_n    = 1'b1;
    play_ready = 1'b0;
    tick();
    chk("post busy", {31'd0, busy}, 32'd0);
    chk("post done", {31'd0, done}, 32'd0);

`ifdef MEM_LFSR_FILL_EN
    run_fill("fill0", 16'h0000);
    run_fill("fillr", 16'(($urandom % 65535) + 1));
    run_play("afterfill", 16, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
